// File: rtl/thermo_pkg.sv
// Shared definitions for the thermometer bar-graph: ramp FSM states and
// the parameter consistency check between level width and bar width.
package thermo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RAMP_DOWN = 2'd2
    } state_t;

    // A K-bit level can light at most 2^K-1 segments, so the bar must be exactly that wide.
    function automatic bit width_ok(input int k, input int w);
        return w == ((1 << k) - 1);
    endfunction

endpackage

// File: rtl/thermometer_encoder.sv
// Combinational binary-to-thermometer encoder: the low 'level' bits of the bar are set.
module thermometer_encoder #(
    parameter int K = 3,
    parameter int W = 7
) (
    input  logic [K-1:0] i_level,
    output logic [W-1:0] o_bar
);

    // Segment i is lit when it sits below the level.
    always_comb begin
        o_bar = '0;
        for (int i = 0; i < W; i++) begin
            o_bar[i] = (i < int'(i_level));
        end
    end

endmodule

// File: rtl/thermo_bargraph.sv
// Thermometer bar-graph: registers a switch word, derives a target level
// (binary in encode mode, thermometer run-length in decode mode), and
// ramps the displayed level one step per tick toward that target.
//
// Handshake/timing note: there is no valid/ready handshake; sw/sel are
// sampled every clock, the target follows the sampled copy combinationally,
// and level moves only on step ticks (one per DIV clocks).
module thermo_bargraph
    import thermo_pkg::*;
#(
    parameter int K   = 3,
    parameter int W   = 7,
    parameter int DIV = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sw,
    input  logic         sel,
    output logic [W-1:0] led,
    output logic [K-1:0] level,
    output logic         busy,
    output logic         err,
    output state_t       dbg_state
);

    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

    generate
        if (!width_ok(K, W)) begin : g_bad_width
            $error("thermo_bargraph: W must equal 2^K-1");
        end
        if (DIV < 1) begin : g_bad_div
            $error("thermo_bargraph: DIV must be at least 1");
        end
    endgenerate

    logic [W-1:0]  r_sw;
    logic          r_sel;
    logic [K-1:0]  r_target;
    logic [K-1:0]  r_level;
    logic [TW-1:0] r_tick;
    logic [W-1:0]  r_led;

    logic [K-1:0]  w_run;
    logic          w_seen_zero;
    logic          w_valid;
    logic [K-1:0]  w_target;
    logic          w_err;
    logic          w_step;
    state_t        w_state;
    logic [K-1:0]  w_level_next;
    logic [W-1:0]  w_bar;

    // Input stage: one register on the switches and the mode select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw  <= '0;
            r_sel <= 1'b0;
        end else begin
            r_sw  <= sw;
            r_sel <= sel;
        end
    end

    // Decode the registered word: run of ones from bit 0, invalid if a 1 sits above a 0.
    always_comb begin
        w_run       = '0;
        w_seen_zero = 1'b0;
        w_valid     = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (!r_sw[i]) begin
                w_seen_zero = 1'b1;
            end else if (w_seen_zero) begin
                w_valid = 1'b0;
            end else begin
                w_run = w_run + K'(1);
            end
        end
    end

    // Target selection; a bad decode word keeps the last good target.
    always_comb begin
        w_err    = r_sel & ~w_valid;
        w_target = r_target;
        if (!r_sel) begin
            w_target = r_sw[K-1:0];
        end else if (w_valid) begin
            w_target = w_run;
        end
    end

    // Remember the target in force so it can be held across invalid input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target <= '0;
        end else begin
            r_target <= w_target;
        end
    end

    // Free-running step tick counter, 0..DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= '0;
        end else if (r_tick == TW'(DIV - 1)) begin
            r_tick <= '0;
        end else begin
            r_tick <= r_tick + TW'(1);
        end
    end

    assign w_step = (r_tick == TW'(DIV - 1));

    // Ramp FSM: state is the comparison of level against target each cycle,
    // so a target change redirects the ramp at the very next step.
    always_comb begin
        w_state      = ST_IDLE;
        w_level_next = r_level;
        if (r_level < w_target) begin
            w_state = ST_RAMP_UP;
        end else if (r_level > w_target) begin
            w_state = ST_RAMP_DOWN;
        end
        if (w_step) begin
            case (w_state)
                ST_RAMP_UP:   w_level_next = r_level + K'(1);
                ST_RAMP_DOWN: w_level_next = r_level - K'(1);
                default:      w_level_next = r_level;
            endcase
        end
    end

    // Level register: moves by at most one per step, never past the target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else begin
            r_level <= w_level_next;
        end
    end

    thermometer_encoder #(
        .K (K),
        .W (W)
    ) u_enc (
        .i_level (r_level),
        .o_bar   (w_bar)
    );

    // Display register: bar in encode mode, zero-extended level in decode mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= '0;
        end else if (r_sel) begin
            r_led <= W'(r_level);
        end else begin
            r_led <= w_bar;
        end
    end

    assign led       = r_led;
    assign level     = r_level;
    assign busy      = (w_state != ST_IDLE);
    assign err       = w_err;
    assign dbg_state = w_state;

endmodule

// File: tb/tb_thermo_bargraph.sv
// Bench for thermo_bargraph: directed scenarios plus randomized switch
// traffic against a cycle-level arithmetic reference model; a second
// instance built with DIV=1 checks the one-step-per-cycle ramp.
module tb_thermo_bargraph;
    import thermo_pkg::*;

    localparam int K   = 3;
    localparam int W   = 7;
    localparam int DIV = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] sw = '0;
    logic         sel = 1'b0;
    logic [W-1:0] led;
    logic [K-1:0] level;
    logic         busy;
    logic         err;
    state_t       dbg_state;

    logic [W-1:0] sw1 = '0;
    logic         sel1 = 1'b0;
    logic [W-1:0] led1;
    logic [K-1:0] level1;
    logic         busy1;
    logic         err1;
    state_t       dbg_state1;

    thermo_bargraph #(.K(K), .W(W), .DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .sel(sel), .led(led),
        .level(level), .busy(busy), .err(err), .dbg_state(dbg_state)
    );

    thermo_bargraph #(.K(K), .W(W), .DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sw(sw1), .sel(sel1), .led(led1),
        .level(level1), .busy(busy1), .err(err1), .dbg_state(dbg_state1)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_sw, m_sel, m_hold, m_level, m_cnt, m_led;

    function automatic int run_len(input int v);
        int n = 0;
        while (n < W && ((v >> n) & 1) == 1) n++;
        return n;
    endfunction

    function automatic bit is_thermo(input int v);
        return v == ((1 << run_len(v)) - 1);
    endfunction

    function automatic int ref_target(input int v, input int s, input int hold);
        if (s == 0) return v % (1 << K);
        if (is_thermo(v)) return run_len(v);
        return hold;
    endfunction

    function automatic int ref_state(input int lv, input int tg);
        if (lv == tg) return int'(ST_IDLE);
        if (lv < tg) return int'(ST_RAMP_UP);
        return int'(ST_RAMP_DOWN);
    endfunction

    task automatic model_reset();
        m_sw = 0; m_sel = 0; m_hold = 0; m_level = 0; m_cnt = 0; m_led = 0;
    endtask

    // Advance the model across one rising edge using the values held before it.
    task automatic model_edge(input int in_sw, input int in_sel);
        int tg;
        tg = ref_target(m_sw, m_sel, m_hold);
        m_led  = (m_sel != 0) ? m_level : ((1 << m_level) - 1);
        if (m_cnt == DIV - 1) begin
            if (m_level < tg) m_level++;
            else if (m_level > tg) m_level--;
        end
        m_hold = tg;
        m_cnt  = (m_cnt + 1) % DIV;
        m_sw   = in_sw;
        m_sel  = in_sel;
    endtask

    task automatic compare_all();
        int tg;
        tg = ref_target(m_sw, m_sel, m_hold);
        check("level", 32'(level), 32'(m_level));
        check("led", 32'(led), 32'(m_led));
        check("busy", 32'(busy), 32'(m_level != tg));
        check("err", 32'(err), 32'((m_sel != 0) && !is_thermo(m_sw)));
        check("state", 32'(dbg_state), 32'(ref_state(m_level, tg)));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step_cycle();
        int s, l;
        @(posedge clk);
        s = int'(sw);
        l = int'(sel);
        if (rst_n) model_edge(s, l);
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step_cycle();
    endtask

    task automatic wait_model_level(input int v, input int budget, input string tag);
        int k = 0;
        while (m_level != v && k < budget) begin
            step_cycle();
            k++;
        end
        check({tag, "_reach"}, 32'(m_level == v), 32'd1);
    endtask

    int rnd;
    int cnt;

    initial begin
        model_reset();
        @(negedge clk);
        compare_all();
        run_cycles(2);
        rst_n = 1'b1;

        // Encode ramp 0 -> 5.
        sel = 1'b0; sw = 7'b0000101;
        run_cycles(30);
        check("enc_level5", 32'(level), 32'd5);
        check("enc_led5", 32'(led), 32'h1f);
        check("enc_busy0", 32'(busy), 32'd0);

        // Decode valid then invalid word; level and target hold at 3.
        sel = 1'b1; sw = 7'b0000111;
        run_cycles(20);
        check("dec_led3", 32'(led), 32'h03);
        check("dec_err0", 32'(err), 32'd0);
        sw = 7'b0000101;
        run_cycles(2);
        check("dec_err1", 32'(err), 32'd1);
        run_cycles(12);
        check("dec_hold3", 32'(level), 32'd3);
        check("dec_hold_idle", 32'(dbg_state), 32'(ST_IDLE));

        // Redirect mid-ramp: head for 6, turn back to 1 at level 3.
        sel = 1'b0; sw = 7'd0;
        wait_model_level(0, 40, "to_zero");
        sw = 7'd6;
        wait_model_level(3, 40, "up_to3");
        sw = 7'd1;
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd1);
        cnt = 0;
        while (exp_q.size() > 0 && cnt < 30) begin
            step_cycle();
            cnt++;
            if (32'(m_level) == exp_q[0]) begin
                check("redir_seq", 32'(level), exp_q.pop_front());
            end
        end
        check("redir_done", 32'(exp_q.size()), 32'd0);
        run_cycles(6);
        check("redir_level1", 32'(level), 32'd1);
        check("redir_busy0", 32'(busy), 32'd0);

        // Asynchronous reset mid-ramp at level 4.
        sw = 7'd7;
        wait_model_level(4, 60, "to_four");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_led", 32'(led), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        run_cycles(2);
        rst_n = 1'b1;
        cnt = 0;
        while (level == '0 && cnt < 20) begin
            step_cycle();
            cnt++;
        end
        check("arst_first_step", 32'(cnt), 32'(DIV));

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                sel = 1'($urandom_range(0, 1));
                rnd = $urandom_range(0, 2);
                if (sel && rnd != 0) sw = W'((1 << $urandom_range(0, W)) - 1);
                else sw = W'($urandom_range(0, (1 << W) - 1));
            end
            step_cycle();
        end

        // DIV=1 instance: one step per cycle, level 7 seven cycles after capture.
        sel = 1'b0; sw = 7'd0;
        sel1 = 1'b0; sw1 = 7'd0;
        run_cycles(10);
        check("div1_start", 32'(level1), 32'd0);
        sw1 = 7'd7;
        step_cycle();
        check("div1_capture", 32'(level1), 32'd0);
        for (int k = 1; k <= 7; k++) begin
            step_cycle();
            check("div1_level", 32'(level1), 32'(k));
        end
        check("div1_busy0", 32'(busy1), 32'd0);
        step_cycle();
        check("div1_led", 32'(led1), 32'h7f);
        check("div1_err", 32'(err1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/thermo_bargraph.md
THERMO_BARGRAPH -- requirements
Module: thermo_bargraph

Interface
REQ-001 The block SHALL have parameter K, default 3, meaning the level width in bits.
REQ-002 The block SHALL have parameter W, default 7, meaning the bar width in bits; W SHALL equal 2^K-1, and elaboration SHALL fail otherwise.
REQ-003 The block SHALL have parameter DIV, default 4, meaning the step-tick period in clock cycles; DIV SHALL be at least 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The block SHALL have port sw, input, W bits: the switch input, either a binary level or a thermometer code.
REQ-007 The block SHALL have port sel, input, 1 bit: the mode; 0 = encode (binary in, bar out), 1 = decode (thermometer in, binary out).
REQ-008 The block SHALL have port led, output, W bits: the registered display.
REQ-009 The block SHALL have port level, output, K bits: the current displayed level.
REQ-010 The block SHALL have port busy, output, 1 bit: high while level differs from target.
REQ-011 The block SHALL have port err, output, 1 bit: high while decode-mode input is not a valid thermometer code.

Function
REQ-012 The block SHALL register sw and sel once (input stage); all target logic SHALL use the registered copies, giving 1 cycle of input latency.
REQ-013 In encode mode, target SHALL equal sw_r[K-1:0].
REQ-014 In decode mode, target SHALL equal the count of contiguous ones starting at bit 0 of sw_r.
REQ-015 A decode input with any 1 above a 0 SHALL set err=1 on the cycle after sampling, and target SHALL hold its last valid value while err=1.
REQ-016 In encode mode, err SHALL be 0.
REQ-017 The tick counter SHALL run freely from 0 to DIV-1 and wrap; a step pulse SHALL occur on the cycle where the count equals DIV-1.
REQ-018 The FSM SHALL have three states, IDLE, RAMP_UP and RAMP_DOWN, evaluated every cycle: IDLE when level==target, RAMP_UP when level<target, RAMP_DOWN when level>target.
REQ-019 On a step pulse, level SHALL move by exactly one toward target: +1 in RAMP_UP, -1 in RAMP_DOWN, unchanged in IDLE.
REQ-020 level SHALL never wrap past 0 or 2^K-1.
REQ-021 A target change mid-ramp SHALL redirect the ramp at the next step pulse, with no jump in level.
REQ-022 When a step pulse and level reaching target coincide, the block SHALL step, then enter IDLE; busy SHALL deassert in the same cycle that level equals target.
REQ-023 A change of sel SHALL NOT reset level; the ramp SHALL continue from the current level toward the new target.
REQ-024 led SHALL be registered: in encode mode it SHALL be the thermometer code of level (the low level bits set); in decode mode it SHALL be {zeros, level}.
REQ-025 led SHALL lag level by one cycle.

Reset
REQ-026 While rst_n=0, the block SHALL immediately, without any clock, force led=0, level=0, busy=0, err=0, target=0, tick count=0, input registers=0 and state=IDLE.
REQ-027 After rst_n deasserts, the first step pulse SHALL occur DIV cycles later.

Structure
REQ-028 The state encoding and the W==2^K-1 check SHALL live in shared package thermo_pkg.
REQ-029 The existing thermometer_encoder SHALL be instantiated as the single sub-module to produce the encode-mode bar from level.

Verification (K=3, W=7, DIV=4)
REQ-030 Reset, sel=0, sw=7'b0000101 -> level SHALL step 1,2,3,4,5 on consecutive ticks 4 cycles apart, final led=7'b0011111, and busy SHALL fall when level=5.
REQ-031 sel=1, sw=7'b0000111 -> after the ramp, led=7'b0000011 and err=0; then sw=7'b0000101 -> err=1, and level and target SHALL stay 3.
REQ-032 sel=0, ramp from 0 toward 6; at level=3 set sw=1 -> level SHALL step 2 then 1, then IDLE with busy=0.
REQ-033 rst_n pulled low asynchronously at level=4 -> led=0 and level=0 before the next clk edge; after release the first step SHALL occur 4 cycles later.
REQ-034 Rebuild with DIV=1, sel=0, sw 0 to 7 -> level SHALL increment every cycle and reach 7 seven cycles after the input register captures sw.
